// File: rtl/cu_pkg.sv
// Shared definitions for control_unit: opcodes, FSM state codes, bus-mux codes, control bundle.
// Build option: CU_BRANCH_EN makes opcode 7 (JN) a legal conditional jump.
package cu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JN  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef logic [2:0] cu_state_t;

  localparam cu_state_t ST_FETCH   = 3'd0;
  localparam cu_state_t ST_DECODE  = 3'd1;
  localparam cu_state_t ST_EX1     = 3'd2;
  localparam cu_state_t ST_EX2     = 3'd3;
  localparam cu_state_t ST_EX3     = 3'd4;
  localparam cu_state_t ST_OPERAND = 3'd5;
  localparam cu_state_t ST_HALT    = 3'd6;

  localparam logic [4:0] MUX_RA   = 5'b10000;
  localparam logic [4:0] MUX_RB   = 5'b01000;
  localparam logic [4:0] MUX_RC   = 5'b00100;
  localparam logic [4:0] MUX_RD   = 5'b00010;
  localparam logic [4:0] MUX_BUF0 = 5'b00001;

  typedef struct packed {
    logic       mem_req;
    logic [3:0] ger_en;
    logic [1:0] buf_en;
    logic [4:0] mux;
    logic       alu_add;
    logic       alu_sub;
    logic       r_en;
    logic       w_en;
    logic       out_valid;
    logic       illegal;
    logic       halted;
  } cu_ctrl_t;

  // Register index 0 is RA, which sits in the MSB of both the enable and mux vectors.
  function automatic logic [3:0] reg_en(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  function automatic logic [4:0] reg_mux(input logic [1:0] idx);
    return MUX_RA >> idx;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_MOV, OP_ADD, OP_SUB, OP_LDI, OP_OUT, OP_JMP, OP_HLT: legal = 1'b1;
`ifdef CU_BRANCH_EN
      OP_JN:   legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Program-memory read port between control_unit (master) and instruction memory (slave).
// Build option CU_BRANCH_EN does not affect this interface.
interface control_unit_if;
  logic       mem_req_o;
  logic       mem_ack_i;
  logic [7:0] mem_addr_o;
  logic [7:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational control decode: maps FSM state + instruction register to datapath controls.
// Build option CU_BRANCH_EN only changes which opcodes count as legal.
module cu_decode
  import cu_pkg::*;
(
  input  logic [7:0] i_ir,
  input  cu_state_t  i_state,
  input  logic       i_ack,
  output cu_ctrl_t   o_ctrl
);

  logic [3:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;

  assign w_op = i_ir[7:4];
  assign w_rd = i_ir[3:2];
  assign w_rs = i_ir[1:0];

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.mem_req = 1'b1;
      end
      ST_DECODE: begin
        o_ctrl.illegal = ~op_legal(w_op);
      end
      ST_EX1: begin
        case (w_op)
          OP_MOV: begin
            o_ctrl.mux    = reg_mux(w_rs);
            o_ctrl.ger_en = reg_en(w_rd);
          end
          OP_ADD, OP_SUB: begin
            o_ctrl.mux    = reg_mux(w_rd);
            o_ctrl.buf_en = 2'b10;
          end
          OP_OUT: begin
            o_ctrl.mux       = reg_mux(w_rs);
            o_ctrl.w_en      = 1'b1;
            o_ctrl.out_valid = 1'b1;
          end
          default: ;
        endcase
      end
      ST_EX2: begin
        o_ctrl.mux     = reg_mux(w_rs);
        o_ctrl.alu_add = (w_op == OP_ADD);
        o_ctrl.alu_sub = (w_op == OP_SUB);
        o_ctrl.buf_en  = 2'b01;
      end
      ST_EX3: begin
        o_ctrl.mux    = MUX_BUF0;
        o_ctrl.ger_en = reg_en(w_rd);
      end
      ST_OPERAND: begin
        // Memory owns the bus for the whole state; LDI captures it only when the byte is valid.
        o_ctrl.mem_req = 1'b1;
        o_ctrl.r_en    = 1'b1;
        if (i_ack && (w_op == OP_LDI)) begin
          o_ctrl.ger_en = reg_en(w_rd);
        end
      end
      ST_HALT: begin
        o_ctrl.halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Micro-sequencer for the 8-bit datapath: owns FSM, PC, IR and the latched ALU sign flag.
// Build option CU_BRANCH_EN enables JN (jump to operand when sign_o is set).
module control_unit
  import cu_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  control_unit_if.master        mem_if,
  input  logic                  alu_sign_i,
  output logic [3:0]            ger_register_en_o,
  output logic [1:0]            alu_buffer_en_o,
  output logic [4:0]            mux1_ctl_o,
  output logic                  alu_add_o,
  output logic                  alu_sub_o,
  output logic                  r_en_o,
  output logic                  w_en_o,
  output logic                  out_valid_o,
  output logic                  sign_o,
  output logic                  illegal_o,
  output logic                  halted_o
);

  cu_state_t  r_state;
  cu_state_t  w_state_nxt;
  logic [7:0] r_pc;
  logic [7:0] w_pc_nxt;
  logic [7:0] r_ir;
  logic [7:0] w_ir_nxt;
  logic       r_sign;
  logic       w_sign_nxt;
  // Low for the first cycle after reset so no request is issued while reset is releasing.
  logic       r_active;

  logic       w_ack;
  logic [3:0] w_op;
  cu_ctrl_t   w_ctrl;
  cu_ctrl_t   w_ctrl_out;

  assign w_ack = r_active & mem_if.mem_ack_i;
  assign w_op  = r_ir[7:4];

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_sign_nxt  = r_sign;
    case (r_state)
      ST_FETCH: begin
        if (w_ack) begin
          w_ir_nxt    = mem_if.mem_rdata_i;
          w_pc_nxt    = r_pc + 8'd1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (w_op)
          OP_MOV, OP_ADD, OP_SUB, OP_OUT: w_state_nxt = ST_EX1;
          OP_LDI, OP_JMP:                 w_state_nxt = ST_OPERAND;
`ifdef CU_BRANCH_EN
          OP_JN:                          w_state_nxt = ST_OPERAND;
`endif
          OP_HLT:                         w_state_nxt = ST_HALT;
          default:                        w_state_nxt = ST_FETCH;
        endcase
      end
      ST_EX1: begin
        w_state_nxt = ((w_op == OP_ADD) || (w_op == OP_SUB)) ? ST_EX2 : ST_FETCH;
      end
      ST_EX2: begin
        w_sign_nxt  = alu_sign_i;
        w_state_nxt = ST_EX3;
      end
      ST_EX3: begin
        w_state_nxt = ST_FETCH;
      end
      ST_OPERAND: begin
        if (w_ack) begin
          w_pc_nxt = r_pc + 8'd1;
          if (w_op == OP_JMP) begin
            w_pc_nxt = mem_if.mem_rdata_i;
          end
`ifdef CU_BRANCH_EN
          if ((w_op == OP_JN) && r_sign) begin
            w_pc_nxt = mem_if.mem_rdata_i;
          end
`endif
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state  <= ST_FETCH;
      r_pc     <= PC_RESET;
      r_ir     <= 8'h00;
      r_sign   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_sign   <= w_sign_nxt;
      r_active <= 1'b1;
    end
  end

  cu_decode u_decode (
    .i_ir    (r_ir),
    .i_state (r_state),
    .i_ack   (w_ack),
    .o_ctrl  (w_ctrl)
  );

  assign w_ctrl_out = r_active ? w_ctrl : '0;

  assign mem_if.mem_req_o  = w_ctrl_out.mem_req;
  assign mem_if.mem_addr_o = r_pc;
  assign ger_register_en_o = w_ctrl_out.ger_en;
  assign alu_buffer_en_o   = w_ctrl_out.buf_en;
  assign mux1_ctl_o        = w_ctrl_out.mux;
  assign alu_add_o         = w_ctrl_out.alu_add;
  assign alu_sub_o         = w_ctrl_out.alu_sub;
  assign r_en_o            = w_ctrl_out.r_en;
  assign w_en_o            = w_ctrl_out.w_en;
  assign out_valid_o       = w_ctrl_out.out_valid;
  assign illegal_o         = w_ctrl_out.illegal;
  assign halted_o          = w_ctrl_out.halted;
  assign sign_o            = r_sign;

  // Datapath safety invariants.
  a_ger_onehot0: assert property (@(posedge clk_i) $onehot0(ger_register_en_o));
  a_mux_onehot0: assert property (@(posedge clk_i) $onehot0(mux1_ctl_o));
  a_bus_excl:    assert property (@(posedge clk_i) !(r_en_o && w_en_o));

endmodule

// File: doc/control_unit.md
# control_unit

Micro-sequencer that fetches instruction bytes from program memory and drives, cycle by cycle, every control input of the 8-bit datapath: register and buffer enables, one-hot bus mux select, ALU add/sub, and bus read/write enables. It sits directly upstream of the operation unit and owns the program counter and the latched ALU sign flag. One instruction executes at a time; there is no overlap or pipelining.

## Interface
Parameters:
- PC_RESET, 8'h00, program counter value loaded on reset.

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- mem_req_o  out  1  program-memory read request.
- mem_ack_i  in  1  memory acknowledge; mem_rdata_i is valid in this cycle.
- mem_addr_o  out  8  read address, equal to the PC.
- mem_rdata_i  in  8  instruction or operand byte.
- alu_sign_i  in  1  combinational ALU sign from the datapath.
- ger_register_en_o  out  4  write enables for RA..RD, with bit3 = RA.
- alu_buffer_en_o  out  2  bit1 = BUF1 load, bit0 = BUF0 load.
- mux1_ctl_o  out  5  one-hot bus select: [4]=RA, [3]=RB, [2]=RC, [1]=RD, [0]=BUF0.
- alu_add_o, alu_sub_o  out  1  ALU operation select.
- r_en_o  out  1  datapath takes the external bus (memory drives it).
- w_en_o  out  1  datapath drives the external bus.
- out_valid_o  out  1  one-cycle strobe that marks an OUT bus write.
- sign_o  out  1  latched sign flag.
- illegal_o  out  1  one-cycle strobe on an undefined opcode.
- halted_o  out  1  high while in HALT.

## Operation
- Instruction byte layout: [7:4] opcode, [3:2] Rd, [1:0] Rs. Register index 0 = RA and 3 = RD.
- Opcodes:
  - 0 NOP.
  - 1 MOV, Rd<-Rs.
  - 2 ADD, Rd<-Rd+Rs.
  - 3 SUB, Rd<-Rd-Rs.
  - 4 LDI, Rd<-next byte.
  - 5 OUT, bus<-Rs.
  - 6 JMP, PC<-next byte.
  - 7 JN (macro-gated).
  - F HLT.
  - All other opcodes execute as NOP and pulse illegal_o.
- States: FETCH, DECODE, EX1, EX2, EX3, OPERAND, HALT.
- FETCH:
  - mem_req_o is held high until mem_ack_i.
  - On ack, IR<-mem_rdata_i, PC<-PC+1 (wraps FF->00), then go to DECODE.
- DECODE:
  - NOP and illegal opcodes go to FETCH.
  - LDI, JMP and JN go to OPERAND.
  - HLT goes to HALT.
  - All other opcodes go to EX1.
- MOV: EX1 sets mux=Rs and ger_en=Rd, then goes to FETCH.
- ADD/SUB:
  - EX1: mux=Rd, alu_buffer_en[1].
  - EX2: mux=Rs, alu_add or alu_sub, alu_buffer_en[0], sign flag<-alu_sign_i.
  - EX3: mux=BUF0, ger_en=Rd, then go to FETCH.
- OUT: EX1 sets mux=Rs, w_en_o=1 and out_valid_o=1, then goes to FETCH.
- OPERAND:
  - mem_req_o is high; r_en_o is high for the whole state.
  - On ack, PC<-PC+1.
  - LDI: asserts ger_en=Rd in the ack cycle.
  - JMP: PC<-mem_rdata_i in the ack cycle, overriding the increment.
  - Then go to FETCH.
- HALT: holds all enables low. Only reset exits HALT.
- At most one ger_register_en_o bit is high in any cycle. r_en_o and w_en_o are never high together. mux1_ctl_o is all-zero in every cycle that does not read the bus.

## Timing
- Reset (rst_i low at an edge):
  - State becomes FETCH, PC=PC_RESET, IR=0, sign_o=0.
  - Every output is 0, including mem_req_o. mem_addr_o shows PC_RESET.
  - Reset applied mid-instruction aborts the instruction with no register enable issued.
- mem_req_o first rises in the cycle after rst_i returns high.
- Fetch with zero-wait ack: FETCH is 1 cycle, DECODE is 1 cycle.
- Instruction cost, given zero-wait memory:
  - NOP: 2 cycles.
  - MOV/OUT: 3 cycles.
  - ADD/SUB: 5 cycles.
  - LDI/JMP: 3 cycles.
- Each cycle without ack in FETCH or OPERAND adds one cycle. Outputs hold during the wait.
- mem_req_o drops the cycle after an ack unless the next state also requests.
- sign_o changes only in the cycle after EX2.

## Configuration
- CU_BRANCH_EN defined: opcode 7 (JN) fetches an operand.
  - If sign_o=1, PC<-operand.
  - Otherwise PC<-PC+1, and the operand is discarded.
  - Cost is 3 cycles.
- CU_BRANCH_EN undefined: opcode 7 is illegal. It pulses illegal_o, fetches no operand, and costs 2 cycles.

## Structure
- Package cu_pkg holds:
  - the opcode constants;
  - the state enumeration;
  - the one-hot mux codes MUX_RA..MUX_BUF0;
  - an index-to-one-hot register-enable function.
- One combinational sub-module, cu_decode: takes IR and state, and produces all datapath control outputs.
- The FSM, PC, IR and sign flag stay in control_unit.

## Test plan
- Reset then NOP at 00 with zero-wait ack:
  - mem_req_o rises 1 cycle after reset release.
  - mem_addr_o steps 00->01 and the next fetch starts at cycle 3.
- LDI RB, 0x5A (bytes 0x44, 0x5A):
  - In the operand ack cycle: r_en_o=1, ger_register_en_o=4'b0100.
  - PC=02 afterwards.
- ADD RA, RC (0x22):
  - EX1 mux=5'b10000 with buf_en=2'b10.
  - EX2 mux=5'b00100 with add=1 and buf_en=2'b01.
  - EX3 mux=5'b00001 with ger_en=4'b1000.
- SUB with alu_sign_i=1 in EX2: sign_o=1 from the next cycle. JN 0x30 under CU_BRANCH_EN then fetches from 30; without the macro, illegal_o pulses.
- JMP 0xFF, then an instruction at FF: PC wraps to 00 after that fetch. A 3-cycle ack delay holds all outputs steady.
- HLT (0xF0): halted_o=1 and no further requests. Pulling rst_i low mid-ADD at EX2 means no ger_en is ever asserted and the outputs return to their reset values.
